// File: rtl/bomberman_map_pkg.sv
// Shared tile-map definitions: geometry helpers, tile encodings and the
// read-arbiter state type used by every map reader.
package bomberman_map_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2,
    GRANT   = 2'd3
  } arb_state_t;

  // Default 2-bit tile encodings; out-of-range reads look like a solid wall.
  localparam logic [1:0] TILE_EMPTY = 2'b00;
  localparam logic [1:0] TILE_WALL  = 2'b01;
  localparam logic [1:0] TILE_BRICK = 2'b10;
  localparam logic [1:0] TILE_OOR   = '1;

  function automatic int map_depth(input int num_row, input int num_col);
    return num_row * num_col;
  endfunction

  function automatic int map_addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/map_read_arbiter_if.sv
// Requester/memory bundle of the tile-map read arbiter. The slave modport is
// the arbiter's view; master is the requesters plus the map memory.
interface map_read_arbiter_if
  import bomberman_map_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int NUM_ROW       = 11,
  parameter int NUM_COL       = 19,
  parameter int MAP_MEM_WIDTH = 2
);
  localparam int ADDR_WIDTH = map_addr_width(map_depth(NUM_ROW, NUM_COL));

  logic [NUM_REQ-1:0]       req;
  logic [ADDR_WIDTH-1:0]    req_addr [NUM_REQ];
  logic [NUM_REQ-1:0]       grant;
  logic [MAP_MEM_WIDTH-1:0] data_out;
  logic [ADDR_WIDTH-1:0]    mem_addr;
  logic [MAP_MEM_WIDTH-1:0] mem_data;
  logic                     busy;

  modport slave  (input req, req_addr, mem_data, output grant, data_out, mem_addr, busy);
  modport master (output req, req_addr, mem_data, input grant, data_out, mem_addr, busy);

endinterface

// File: rtl/map_read_arbiter_rr_priority_pick.sv
// Combinational rotating-priority picker: first set request at or above ptr,
// wrapping modulo NUM_REQ. Tie ptr to 0 for plain lowest-index priority.
module rr_priority_pick
  import bomberman_map_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Scan from the farthest offset down so the nearest hit to ptr wins.
  always_comb begin
    valid    = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand     = (int'(ptr) + i) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (req[cand_idx]) begin
        valid = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/map_read_arbiter.sv
// Shares the tile-map read port among NUM_REQ readers, one read in flight.
// Round-robin by default; define MAP_ARB_FIXED_PRIO_EN for lowest-index-wins.
module map_read_arbiter
  import bomberman_map_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int NUM_ROW       = 11,
  parameter int NUM_COL       = 19,
  parameter int MAP_MEM_WIDTH = 2,
  parameter int MEM_LATENCY   = 1
) (
  input  logic               clk,
  input  logic               rst,
  map_read_arbiter_if.slave  bus
);

  localparam int DEPTH      = map_depth(NUM_ROW, NUM_COL);
  localparam int ADDR_WIDTH = map_addr_width(DEPTH);
  localparam int IDX_W      = idx_width(NUM_REQ);
  localparam int CNT_W      = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  // Out-of-range reads saturate to the all-ones wall tile.
  function automatic logic [MAP_MEM_WIDTH-1:0] capture_tile(
    input logic                     oor_f,
    input logic [MAP_MEM_WIDTH-1:0] d
  );
    return oor_f ? {MAP_MEM_WIDTH{1'b1}} : d;
  endfunction

  // Extra top bit keeps the compare correct when DEPTH is a power of two.
  function automatic logic addr_oor(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} >= (ADDR_WIDTH + 1)'(DEPTH));
  endfunction

  arb_state_t            state;
  arb_state_t            state_nxt;
  logic [IDX_W-1:0]      winner;
  logic                  oor;
  logic [CNT_W-1:0]      wait_cnt;
  logic                  pick_vld;
  logic [IDX_W-1:0]      pick_idx;
  logic [IDX_W-1:0]      pick_ptr;
  logic [ADDR_WIDTH-1:0] pick_addr;
  logic                  pick_oor;

`ifdef MAP_ARB_FIXED_PRIO_EN
  assign pick_ptr = '0;
`else
  logic [IDX_W-1:0] rr_ptr;
  assign pick_ptr = rr_ptr;
`endif

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (bus.req),
    .ptr   (pick_ptr),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  assign pick_addr = bus.req_addr[pick_idx];
  assign pick_oor  = addr_oor(pick_addr);
  assign bus.busy  = (state != IDLE);

  always_comb begin
    state_nxt = state;
    bus.grant = '0;
    case (state)
      IDLE:    if (pick_vld) state_nxt = WAIT;
      WAIT:    if (wait_cnt == CNT_LAST) state_nxt = CAPTURE;
      CAPTURE: state_nxt = GRANT;
      GRANT: begin
        bus.grant[winner] = 1'b1;
        state_nxt         = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      winner       <= '0;
      oor          <= 1'b0;
      wait_cnt     <= '0;
      bus.mem_addr <= '0;
      bus.data_out <= '0;
`ifndef MAP_ARB_FIXED_PRIO_EN
      rr_ptr       <= '0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        // ---- accept: latch winner, present address to memory
        IDLE: begin
          if (pick_vld) begin
            winner       <= pick_idx;
            oor          <= pick_oor;
            bus.mem_addr <= pick_oor ? '0 : pick_addr;
            wait_cnt     <= '0;
          end
        end
        // ---- memory latency
        WAIT: wait_cnt <= (wait_cnt == CNT_LAST) ? '0 : wait_cnt + CNT_W'(1);
        // ---- capture read data
        CAPTURE: bus.data_out <= capture_tile(oor, bus.mem_data);
        // ---- grant: advance rotation past the served requester
        GRANT: begin
`ifndef MAP_ARB_FIXED_PRIO_EN
          rr_ptr <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_map_read_arbiter.sv
// Bench for map_read_arbiter: directed scenarios on a latency-1 and a
// latency-3 instance, then randomized traffic against a transaction model.
module tb_map_read_arbiter;
  import bomberman_map_pkg::*;

  localparam int NR    = 2;
  localparam int ROWS  = 11;
  localparam int COLS  = 19;
  localparam int MW    = 2;
  localparam int DEPTH = ROWS * COLS;
  localparam int AW    = $clog2(DEPTH);
  localparam int IW    = 1;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [MW-1:0] mem [0:(1<<AW)-1];

  map_read_arbiter_if #(.NUM_REQ(NR), .NUM_ROW(ROWS), .NUM_COL(COLS), .MAP_MEM_WIDTH(MW)) bus_a ();
  map_read_arbiter_if #(.NUM_REQ(NR), .NUM_ROW(ROWS), .NUM_COL(COLS), .MAP_MEM_WIDTH(MW)) bus_b ();

  map_read_arbiter #(.NUM_REQ(NR), .NUM_ROW(ROWS), .NUM_COL(COLS), .MAP_MEM_WIDTH(MW),
                     .MEM_LATENCY(LAT_A)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  map_read_arbiter #(.NUM_REQ(NR), .NUM_ROW(ROWS), .NUM_COL(COLS), .MAP_MEM_WIDTH(MW),
                     .MEM_LATENCY(LAT_B)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  // Map memory models: data appears LAT cycles after the address.
  logic [MW-1:0] rd_a, rd_b0, rd_b1, rd_b2;
  always @(posedge clk) begin
    rd_a  <= mem[bus_a.mem_addr];
    rd_b0 <= mem[bus_b.mem_addr];
    rd_b1 <= rd_b0;
    rd_b2 <= rd_b1;
  end
  assign bus_a.mem_data = rd_a;
  assign bus_b.mem_data = rd_b2;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    bus_a.req = '0;
    bus_b.req = '0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_a.req = '0; bus_b.req = '0;
    bus_a.req_addr[0] = '0; bus_a.req_addr[1] = '0;
    bus_b.req_addr[0] = '0; bus_b.req_addr[1] = '0;
    step(2);
    checks++; if (bus_a.grant !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b want=00", bus_a.grant); end
    checks++; if (bus_a.data_out !== 2'b00) begin failures++; $display("FAIL reset_data got=%b want=00", bus_a.data_out); end
    checks++; if (bus_a.mem_addr !== '0) begin failures++; $display("FAIL reset_mem_addr got=%0d want=0", bus_a.mem_addr); end
    checks++; if (bus_a.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus_a.busy); end
    checks++; if (bus_b.busy !== 1'b0 || bus_b.grant !== 2'b00) begin
      failures++; $display("FAIL reset_b got busy=%b grant=%b want 0/00", bus_b.busy, bus_b.grant); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    logic [NR-1:0] exp_g;
    do_reset();
    mem[20] = 2'b10;
    bus_a.req_addr[0] = AW'(20);
    bus_a.req = 2'b01;
    for (int k = 1; k <= 4; k++) begin
      step();
      exp_g = (k == 3) ? 2'b01 : 2'b00;
      checks++; if (bus_a.grant !== exp_g) begin failures++; $display("FAIL single_grant T+%0d got=%b want=%b", k, bus_a.grant, exp_g); end
      checks++; if (bus_a.busy !== (k <= 3)) begin failures++; $display("FAIL single_busy T+%0d got=%b want=%b", k, bus_a.busy, (k <= 3)); end
      if (k == 1) begin
        checks++; if (bus_a.mem_addr !== AW'(20)) begin failures++; $display("FAIL single_mem_addr got=%0d want=20", bus_a.mem_addr); end
      end
      if (k == 3) begin
        checks++; if (bus_a.data_out !== 2'b10) begin failures++; $display("FAIL single_data got=%b want=10", bus_a.data_out); end
        bus_a.req = 2'b00;
      end
    end
  endtask

  task automatic test_alternate();
    logic [NR-1:0] exp_g;
    logic [MW-1:0] exp_d;
    int n;
    do_reset();
    mem[5] = 2'b01; mem[6] = 2'b10;
    bus_a.req_addr[0] = AW'(5);
    bus_a.req_addr[1] = AW'(6);
    bus_a.req = 2'b11;
    for (int k = 1; k <= 16; k++) begin
      step();
      exp_g = 2'b00;
      exp_d = 2'b01;
      if (k % 4 == 3) begin
        n = k / 4;
`ifdef MAP_ARB_FIXED_PRIO_EN
        exp_g = 2'b01;
`else
        exp_g = (n % 2 == 0) ? 2'b01 : 2'b10;
`endif
        exp_d = (exp_g == 2'b01) ? 2'b01 : 2'b10;
      end
      checks++; if (bus_a.grant !== exp_g) begin failures++; $display("FAIL alt_grant T+%0d got=%b want=%b", k, bus_a.grant, exp_g); end
      if (k % 4 == 3) begin
        checks++; if (bus_a.data_out !== exp_d) begin failures++; $display("FAIL alt_data T+%0d got=%b want=%b", k, bus_a.data_out, exp_d); end
      end
    end
    bus_a.req = 2'b00;
    step(4);
  endtask

  task automatic test_oor();
    do_reset();
    mem[20] = 2'b10; mem[0] = 2'b01;
    bus_a.req_addr[0] = AW'(20);
    bus_a.req = 2'b01;
    step(3);
    bus_a.req = 2'b00;
    checks++; if (bus_a.mem_addr !== AW'(20)) begin failures++; $display("FAIL oor_pre_addr got=%0d want=20", bus_a.mem_addr); end
    step();
    bus_a.req_addr[0] = AW'(DEPTH);
    bus_a.req = 2'b01;
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++; if (bus_a.mem_addr !== '0) begin failures++; $display("FAIL oor_mem_addr T+%0d got=%0d want=0", k, bus_a.mem_addr); end
      checks++; if (bus_a.grant !== ((k == 3) ? 2'b01 : 2'b00)) begin
        failures++; $display("FAIL oor_grant T+%0d got=%b want=%b", k, bus_a.grant, ((k == 3) ? 2'b01 : 2'b00)); end
    end
    checks++; if (bus_a.data_out !== 2'b11) begin failures++; $display("FAIL oor_data got=%b want=11", bus_a.data_out); end
    bus_a.req = 2'b00;
    step();
  endtask

  task automatic test_reset_mid();
    // data_out currently holds the wall tile from the previous scenario
    bus_a.req_addr[0] = AW'(20);
    bus_a.req = 2'b01;
    step();
    rst = 1'b1;
    bus_a.req = 2'b00;
    step();
    rst = 1'b0;
    checks++; if (bus_a.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b want=0", bus_a.busy); end
    checks++; if (bus_a.data_out !== 2'b00) begin failures++; $display("FAIL rstmid_data got=%b want=00", bus_a.data_out); end
    checks++; if (bus_a.mem_addr !== '0) begin failures++; $display("FAIL rstmid_mem_addr got=%0d want=0", bus_a.mem_addr); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (bus_a.grant !== 2'b00) begin failures++; $display("FAIL rstmid_grant +%0d got=%b want=00", k, bus_a.grant); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    mem[5] = 2'b01; mem[6] = 2'b10;
    bus_a.req_addr[0] = AW'(5);
    bus_a.req = 2'b01;
    step();
    bus_a.req_addr[1] = AW'(6);
    bus_a.req = 2'b11;
    for (int k = 2; k <= 7; k++) begin
      step();
      checks++; if (bus_a.grant !== ((k == 3) ? 2'b01 : (k == 7) ? 2'b10 : 2'b00)) begin
        failures++; $display("FAIL b2b_grant T+%0d got=%b want=%b", k, bus_a.grant, ((k == 3) ? 2'b01 : (k == 7) ? 2'b10 : 2'b00)); end
      if (k == 3) begin
        checks++; if (bus_a.data_out !== 2'b01) begin failures++; $display("FAIL b2b_data0 got=%b want=01", bus_a.data_out); end
        bus_a.req = 2'b10;
      end
      if (k == 7) begin
        checks++; if (bus_a.data_out !== 2'b10) begin failures++; $display("FAIL b2b_data1 got=%b want=10", bus_a.data_out); end
        bus_a.req = 2'b00;
      end
    end
    step();
  endtask

  task automatic test_latency3();
    do_reset();
    mem[77] = 2'b10;
    bus_b.req_addr[0] = AW'(77);
    bus_b.req = 2'b01;
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++; if (bus_b.grant !== ((k == 5) ? 2'b01 : 2'b00)) begin
        failures++; $display("FAIL lat3_grant T+%0d got=%b want=%b", k, bus_b.grant, ((k == 5) ? 2'b01 : 2'b00)); end
      checks++; if (bus_b.busy !== (k <= 5)) begin failures++; $display("FAIL lat3_busy T+%0d got=%b want=%b", k, bus_b.busy, (k <= 5)); end
      if (k == 5) begin
        checks++; if (bus_b.data_out !== 2'b10) begin failures++; $display("FAIL lat3_data got=%b want=10", bus_b.data_out); end
        bus_b.req = 2'b00;
      end
    end
  endtask

  // Transaction-level model: an idle arbiter accepts the next requester in
  // rotation; its grant lands LAT+2 cycles later and it is free after LAT+3.
  task automatic test_random();
    int m_ptr, busy_left, gnt_cd, win, c, rq_i;
    logic [NR-1:0] exp_g;
    logic [MW-1:0] m_data;
    logic [AW-1:0] a;
    do_reset();
    for (int i = 0; i < (1 << AW); i++) mem[i] = MW'($urandom);
    m_ptr = 0; busy_left = 0; gnt_cd = -1; win = 0; m_data = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int r = 0; r < NR; r++) begin
        if (!bus_a.req[IW'(r)] && $urandom_range(0, 3) == 0) begin
          bus_a.req[IW'(r)] = 1'b1;
          if ($urandom_range(0, 9) == 0)
            bus_a.req_addr[IW'(r)] = AW'($urandom_range(DEPTH, (1 << AW) - 1));
          else
            bus_a.req_addr[IW'(r)] = AW'($urandom_range(0, DEPTH - 1));
        end
      end
      rq_i = int'(bus_a.req);
      if (busy_left == 0 && rq_i != 0) begin
`ifdef MAP_ARB_FIXED_PRIO_EN
        win = ((rq_i & 1) != 0) ? 0 : 1;
`else
        win = -1;
        for (int i = 0; i < NR; i++) begin
          c = (m_ptr + i) % NR;
          if (win < 0 && ((rq_i >> c) & 1) != 0) win = c;
        end
        m_ptr = (win + 1) % NR;
`endif
        a = bus_a.req_addr[IW'(win)];
        m_data = (int'(a) >= DEPTH) ? {MW{1'b1}} : mem[a];
        gnt_cd = 2 + LAT_A;
        busy_left = 3 + LAT_A;
      end
      step();
      if (busy_left > 0) busy_left--;
      if (gnt_cd >= 0) gnt_cd--;
      exp_g = (gnt_cd == 0) ? NR'(1 << win) : '0;
      checks++; if (bus_a.grant !== exp_g) begin failures++; $display("FAIL rnd_grant cyc=%0d got=%b want=%b", cyc, bus_a.grant, exp_g); end
      checks++; if (bus_a.busy !== (busy_left > 0)) begin failures++; $display("FAIL rnd_busy cyc=%0d got=%b want=%b", cyc, bus_a.busy, (busy_left > 0)); end
      if (gnt_cd == 0) begin
        checks++; if (bus_a.data_out !== m_data) begin failures++; $display("FAIL rnd_data cyc=%0d got=%b want=%b", cyc, bus_a.data_out, m_data); end
        bus_a.req[IW'(win)] = 1'b0;
      end
    end
    bus_a.req = '0;
    step(8);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    test_reset();
    test_single();
    test_alternate();
    test_oor();
    test_reset_mid();
    test_back_to_back();
    test_latency3();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/map_read_arbiter.md
Name: map_read_arbiter

Overview:
- Shares the single read port of the tile-map memory (NUM_ROW x NUM_COL tiles, MAP_MEM_WIDTH bits each) among several readers.
- Readers are the per-player obstacle checkers inside each player_controller, plus the bomb/explosion logic.
- Sits directly upstream of player_controller: it consumes that block's read_req / map_addr and drives its read_granted / map_mem_in.
- Round-robin arbitration, one outstanding memory read at a time.

Parameters:
- NUM_REQ, 2, number of requesters (at least 1).
- NUM_ROW, 11, map rows.
- NUM_COL, 19, map columns.
- MAP_MEM_WIDTH, 2, bits per tile entry.
- MEM_LATENCY, 1, memory read latency in cycles from mem_addr valid to mem_data valid (at least 1).
- localparam DEPTH = NUM_ROW*NUM_COL.
- localparam ADDR_WIDTH = $clog2(DEPTH).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester read request (level)
- req_addr  in  NUM_REQ x ADDR_WIDTH  per-requester tile address (unpacked array)
- grant  out  NUM_REQ  one-cycle pulse; data_out valid for that requester
- data_out  out  MAP_MEM_WIDTH  read data, broadcast to all requesters
- mem_addr  out  ADDR_WIDTH  address to map memory read port
- mem_data  in  MAP_MEM_WIDTH  map memory read data
- busy  out  1  transaction in flight (state != IDLE)

Interface decided: one clock; reset is synchronous and active-high; clock port clk, reset port rst.

Behaviour:
- Reset values: grant=0, data_out=0, mem_addr=0, busy=0, state=IDLE, rr_ptr=0, wait counter=0.
- Requester contract: hold req high and req_addr stable until its grant pulse. Sample data_out only in the grant cycle.
- FSM states and transitions:
  - IDLE: if any req bit is set, pick a winner. Search starts at rr_ptr, ascending, wrapping modulo NUM_REQ. Register winner index and mem_addr <= req_addr[winner]. Go to WAIT. With no req, stay in IDLE.
  - WAIT: count MEM_LATENCY cycles, then go to CAPTURE.
  - CAPTURE: data_out <= mem_data (the OOR rule below overrides this). Go to GRANT.
  - GRANT: grant[winner]=1 for this cycle only. rr_ptr <= (winner+1) mod NUM_REQ. Go to IDLE.
- Latency: req sampled in IDLE at cycle T gives grant and data_out at cycle T+2+MEM_LATENCY (T+3 at default).
  - Next arbitration happens at cycle T+3+MEM_LATENCY.
  - Throughput: one read per MEM_LATENCY+3 cycles.
- data_out holds its value until the next CAPTURE.
- mem_addr holds its value between transactions.
- At most one grant bit is high in any cycle.
- Out-of-range address (req_addr >= DEPTH):
  - Full normal latency still applies.
  - data_out = TILE_OOR (all ones, treated as a wall).
  - mem_data is ignored.
  - mem_addr is driven to 0.
- Requester drops req mid-transaction: the transaction still completes and the grant still pulses. The requester ignores it.
- Requests arriving while busy are not lost; they are evaluated at the next IDLE.
- Simultaneous requests from all requesters are served in rotation. No requester waits more than NUM_REQ transactions.
- NUM_REQ=1: rr_ptr stays 0.
- rst at any state, including mid-WAIT: return to IDLE next cycle, all outputs at reset values, no grant issued.

Optional Feature:
- MAP_ARB_FIXED_PRIO_EN defined:
  - Fixed priority; the lowest index always wins.
  - rr_ptr is removed; winner selection starts at index 0.
- Not defined: round-robin as above.
- Latency, OOR handling and the handshake are identical in both modes.

Decomposition:
- Shared package bomberman_map_pkg:
  - DEPTH, ADDR_WIDTH derivation helpers.
  - Tile encodings: TILE_EMPTY, TILE_WALL, TILE_BRICK, TILE_OOR='1.
  - arb_state_t enum {IDLE, WAIT, CAPTURE, GRANT}.
- One natural sub-module: rr_priority_pick. It is combinational, takes req and rr_ptr, and returns a valid flag and the winner index. In fixed-priority mode it is instantiated with ptr tied to 0.

Test Plan:
- Reset, then req=2'b01, req_addr[0]=20, memory word 20 = 2'b10 → grant=2'b01 exactly at cycle T+3, data_out=2'b10, busy high for cycles T+1..T+3.
- req=2'b11 held continuously, addrs 5 and 6 → grants alternate 01,10,01,10 every 4 cycles with matching data. Under MAP_ARB_FIXED_PRIO_EN, grant=01 every 4 cycles and requester 1 is starved.
- req_addr[0]=209 (DEPTH) → grant at T+3 with data_out=2'b11; mem_addr stays 0.
- rst asserted in the cycle after IDLE accepts a request → no grant pulse; busy=0, data_out=0 the cycle after rst.
- req[1] raised while busy serving requester 0 → requester 1 granted in the immediately following transaction, grant at the previous grant cycle + 4.
- MEM_LATENCY=3, single request → grant at T+5 with correct data.
